// File: rtl/display_mux.sv
// display_mux: synchronises TMS1000 R/O outputs into per-digit RAM and scans it onto a common-cathode 7-seg display (DISPLAY_MUX_PERSIST_EN keeps digits after their strobe drops).
// Latency: input change to digit_ram 4 raw_clk edges, to segments 5; all outputs registered.
// Backpressure: none; free-running scan, inputs sampled every cycle.
module display_mux #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              raw_clk,
  input  logic              button_reset,
  input  logic [10:0]       pins_r,
  input  logic [7:0]        pins_o,
  output logic [DIGITS-1:0] digit_sel,
  output logic [7:0]        segments,
  output logic              frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  logic [DIGITS-1:0] r_s1, r_s2, r_s3;
  logic [7:0]        o_s1, o_s2, o_s3;
  logic              stable;
  logic [7:0]        digit_ram [DIGITS];

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              wrap;

  logic [DIGITS-1:0] sel_nxt;
  logic [7:0]        seg_nxt;
  logic              fd_nxt;

  generate
    if (DIGITS < 11) begin : g_unused_r
      logic unused_r_hi;
      assign unused_r_hi = ^pins_r[10:DIGITS];
    end
  endgenerate

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      o_s1 <= '0;
      o_s2 <= '0;
      o_s3 <= '0;
    end else begin
      r_s1 <= pins_r[DIGITS-1:0];
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      o_s1 <= pins_o;
      o_s2 <= o_s1;
      o_s3 <= o_s2;
    end
  end

  // Two matching samples reject any glitch shorter than two raw_clk cycles.
  assign stable = (r_s2 == r_s3) && (o_s2 == o_s3);

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      for (int i = 0; i < DIGITS; i++) digit_ram[i] <= '0;
    end else if (stable) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_s3[i]) begin
          digit_ram[i] <= o_s3;
        end
`ifndef DISPLAY_MUX_PERSIST_EN
        else begin
          digit_ram[i] <= '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    wrap      = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_DRIVE;
          cnt_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins track the FSM cycle-for-cycle.
  always_comb begin
    sel_nxt = '1;
    seg_nxt = '0;
    fd_nxt  = wrap;
    if (state_nxt == ST_DRIVE) begin
      sel_nxt = ~(DIGITS'(1) << idx_nxt);
      seg_nxt = digit_ram[idx_nxt];
    end
  end

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      digit_sel  <= '1;
      segments   <= '0;
      frame_done <= 1'b0;
    end else begin
      digit_sel  <= sel_nxt;
      segments   <= seg_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: doc/display_mux.md
# display_mux

Multiplexed 7-segment display driver that sits directly downstream of the TMS1000 core. It samples the core's R strobe lines and O segment outputs, which come from the slow CPU clock domain, into per-digit segment storage. It then scans that storage onto a common-cathode LED display at a fixed refresh rate, with inter-digit blanking to prevent ghosting. It runs entirely on the raw board clock, so display refresh is independent of CPU halts and stalls.

## Interface
Parameters:
- DIGITS, 8, number of digit positions; digit i is strobed by pins_r[i]; legal range 1–11.
- REFRESH_DIV, 12000, raw_clk cycles each digit is driven per scan slot (1 kHz/digit at 12 MHz); must be ≥1.
- BLANK_CYCLES, 16, raw_clk cycles of all-off between digits; must be ≥1.

Ports:
- raw_clk  in  1  board clock (12 MHz); single clock domain.
- button_reset  in  1  asynchronous, active-low reset.
- pins_r  in  11  core R outputs; asynchronous to raw_clk.
- pins_o  in  8  core O outputs (segment pattern, bit6=a … bit0=g, bit7=dp); asynchronous to raw_clk.
- digit_sel  out  DIGITS  digit enables, active-low, at most one low.
- segments  out  8  segment drive, active-high, same bit order as pins_o.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation
- Input capture:
  - pins_r[DIGITS-1:0] and pins_o each pass through a 3-flop chain (s1, s2, s3).
  - The sample is "stable" when s2 == s3 for both buses.
  - On a stable cycle, digit_ram[i] <= s3 of pins_o for every i with s3 of pins_r[i] = 1.
  - Several R bits high at once write all of those digits in the same cycle.
  - R bits ≥ DIGITS are ignored.
- Storage: digit_ram is DIGITS × 8 bits, all zero after reset.
- Scan FSM, states BLANK and DRIVE, counter cnt, index idx:
  - BLANK: digit_sel all ones, segments = 0. After BLANK_CYCLES cycles → DRIVE, cnt cleared.
  - DRIVE: digit_sel[idx] = 0, segments = digit_ram[idx] read live, so a write to the driven digit appears on the next cycle. After REFRESH_DIV cycles → BLANK.
  - On DRIVE → BLANK, idx increments. If idx = DIGITS-1, idx wraps to 0 and frame_done pulses for one cycle, coincident with the first BLANK cycle.
- Reset mid-operation: all outputs go to reset values immediately, digit_ram clears, FSM restarts in BLANK at idx 0.
- The display never drives two digits at once. Every digit transition includes ≥1 BLANK cycle.

## Timing
- Reset values: digit_sel = all ones, segments = 0, frame_done = 0, idx = 0, state = BLANK, cnt = 0, digit_ram = 0.
- All outputs are registered, with no combinational path from the inputs.
- Capture latency: inputs held constant from edge k → digit_ram updated at edge k+4. If the driven digit is updated, segments changes at edge k+5.
- Input glitches shorter than 2 raw_clk cycles are never written.
- First DRIVE after reset starts at edge BLANK_CYCLES. digit_sel[0] is low for exactly REFRESH_DIV cycles.
- Frame period: DIGITS × (BLANK_CYCLES + REFRESH_DIV) cycles.
- frame_done period equals the frame period. Its first pulse comes DIGITS × (BLANK_CYCLES + REFRESH_DIV) cycles after reset release.
- An input change during BLANK is written normally and shows at the next DRIVE of that digit.

## Configuration
- DISPLAY_MUX_PERSIST_EN defined:
  - digit_ram retains each digit's last written pattern after its R bit falls.
  - Matches software that strobes each digit once and moves on.
- DISPLAY_MUX_PERSIST_EN undefined:
  - On every stable cycle, digit_ram[i] <= 0 for each i < DIGITS whose s3 R bit is 0.
  - Digits therefore show only while the core holds their R line high, mirroring direct wiring.
  - All other behaviour is identical.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless stated.
- Reset: hold button_reset low, then release → digit_sel=4'b1111, segments=0 for 2 cycles; then digit_sel=4'b1110, segments=0 for 8 cycles.
- Capture: pins_r=0x004, pins_o=0x7E held 10 cycles, then pins_r=0 → during digit 2's slot, digit_sel=4'b1011 and segments=0x7E. Digits 0, 1, 3 show 0x00.
- Glitch: pins_r=0x001 for 1 cycle with pins_o=0x30 → digit_ram[0] remains 0.
- Multi-write and wrap: pins_r=0x00F, pins_o=0x7F → all four digits show 0x7F. frame_done pulses once every 40 cycles, on the first BLANK cycle after digit 3.
- Persist mode: with DISPLAY_MUX_PERSIST_EN, write digit 1 with 0x33, then drop pins_r → 0x33 is still shown next frame. Without the macro → 0x00 within 4 cycles of the drop.
- Async reset mid-DRIVE of digit 2 → digit_sel=4'b1111, segments=0 in the same cycle. digit_ram is cleared, and the scan resumes at idx 0.
